// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed scanner for a common-anode 7-segment display
// Holds a packed BCD value and presents one nibble plus one active-low digit enable per slot.
module bcd_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank_lz,
  output logic                  w0,
  output logic                  w1,
  output logic                  w2,
  output logic                  w3,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  invalid
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [4*DIGITS-1:0] held_q;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          w_q, w_d;
  logic [IDX_W-1:0]    didx_q;
  logic                inv_q;

  logic [DIGITS-1:0]   upper_zero;
  logic                cur_blank;
  logic                load_invalid;
  logic                presc_wrap;

  // upper_zero[i]: digits i..DIGITS-1 of the held value are all zero
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (held_q[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (held_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_blank = 1'b0;
    w_d       = 4'b1111;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_blank = blank_lz && (i != 0) && upper_zero[i];
        if (!(blank_lz && (i != 0) && upper_zero[i])) begin
          w_d     = held_q[4*i +: 4];
          an_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        load_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    presc_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PRE_W'(1);
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      w_q     <= 4'b1111;
      didx_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      w_q     <= w_d;
      didx_q  <= idx_q;
      if (load) begin
        held_q <= bcd_in;
        inv_q  <= load_invalid;
      end
    end
  end

  assign {w3, w2, w1, w0} = w_q;
  assign an        = an_q;
  assign digit_idx = didx_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner
// Driver queues the expected registered outputs per edge; a negedge monitor pops and compares.
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic        w0, w1, w2, w3;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        invalid;

  bcd_display_scanner #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .blank_lz(blank_lz),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .an(an), .digit_idx(digit_idx), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] w;
    logic [1:0] idx;
    logic       inv;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   nedge = 0;
  logic [15:0] model_held = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] digit_of(logic [15:0] v, int s);
    logic [15:0] t;
    t = v >> (4 * s);
    return t[3:0];
  endfunction

  function automatic bit is_blank(logic [15:0] v, int s, logic blz);
    logic [15:0] t;
    t = v >> (4 * s);
    return blz && (s > 0) && (t == 16'h0);
  endfunction

  // Expected outputs after this edge come from the slot selected before it and the pre-load value.
  task automatic drive(input logic r, input logic ld, input logic [15:0] v,
                       input logic blz, input logic exp_inv);
    exp_t e;
    int   slot;
    e.cyc = cyc + 1;
    if (r) begin
      e.an = 4'b1111; e.w = 4'b1111; e.idx = 2'd0; e.inv = 1'b0;
      nedge = 0;
      model_held = 16'h0;
    end else begin
      nedge++;
      slot  = ((nedge - 1) / 4) % 4;
      e.idx = 2'(slot);
      e.inv = exp_inv;
      if (is_blank(model_held, slot, blz)) begin
        e.an = 4'b1111; e.w = 4'b1111;
      end else begin
        e.an = ~(4'b0001 << slot);
        e.w  = digit_of(model_held, slot);
      end
      if (ld) model_held = v;
    end
    q.push_back(e);
    rst = r; load = ld; bcd_in = v; blank_lz = blz;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests_run++;
      if (e.cyc != cyc) begin
        tests_failed++;
        $display("FAIL stale_entry cyc=%0d got_cyc=%0d", e.cyc, cyc);
      end
      tests_run++;
      if (an !== e.an) begin
        tests_failed++;
        $display("FAIL an cyc=%0d actual=%b required=%b", cyc, an, e.an);
      end
      tests_run++;
      if ({w3, w2, w1, w0} !== e.w) begin
        tests_failed++;
        $display("FAIL w cyc=%0d actual=%h required=%h", cyc, {w3, w2, w1, w0}, e.w);
      end
      tests_run++;
      if (digit_idx !== e.idx) begin
        tests_failed++;
        $display("FAIL digit_idx cyc=%0d actual=%0d required=%0d", cyc, digit_idx, e.idx);
      end
      tests_run++;
      if (invalid !== e.inv) begin
        tests_failed++;
        $display("FAIL invalid cyc=%0d actual=%b required=%b", cyc, invalid, e.inv);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
    // reset, then first drive of digit 0
    repeat (3) drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    // 1234 scanned through a full wrap
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    repeat (18) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    // leading-zero blanking, then value zero
    drive(1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
    repeat (15) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    repeat (15) drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    // non-BCD nibble sets invalid and passes through; valid load clears it
    drive(1'b0, 1'b1, 16'h12A4, 1'b0, 1'b1);
    repeat (15) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    // load on the wrap edge from index 3
    drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    // mid-slot reset at index 2 with load asserted (ignored)
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Time-multiplexed driver for a multi-digit common-anode 7-segment display.
- Latches a packed multi-digit BCD value and cycles through its digits at a programmable refresh rate.
- Each cycle it presents one BCD nibble on w3..w0 for the downstream BCD-to-7-segment convertor, plus one active-low digit enable.
- Supports optional leading-zero blanking and flags non-BCD nibbles.

Parameters:
DIGITS, 4, number of display digits; legal range 1..8
REFRESH_DIV, 100000, clock cycles each digit stays selected; legal range >= 1

Ports:
clk  input  1  system clock; single clock domain, rising edge
rst  input  1  synchronous, active-high reset
load  input  1  when high at a rising edge, bcd_in is latched
bcd_in  input  4*DIGITS  packed BCD value; digit 0 (least significant) in bits [3:0]
blank_lz  input  1  1 = blank leading zeros; sampled every cycle, not latched
w0  output  1  BCD nibble bit 0 to convertor
w1  output  1  BCD nibble bit 1
w2  output  1  BCD nibble bit 2
w3  output  1  BCD nibble bit 3
an  output  DIGITS  active-low digit enables; at most one bit low
digit_idx  output  clog2(DIGITS), min 1  index of the digit currently driven
invalid  output  1  held value contains a nibble > 9

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Internal state:
  - held value (4*DIGITS bits)
  - prescaler, 0..REFRESH_DIV-1
  - scan index, 0..DIGITS-1
- Reset: applies at any rising edge with rst=1, including mid-scan; load is ignored while rst=1. All of the following take effect at that edge:
  - held = 0, prescaler = 0, index = 0
  - an = all ones (all off)
  - {w3,w2,w1,w0} = 4'b1111 (blank code; convertor drives all segments off)
  - digit_idx = 0, invalid = 0
- Prescaler:
  - Increments each non-reset cycle.
  - At REFRESH_DIV-1 it wraps to 0 and index advances by 1; index wraps from DIGITS-1 to 0.
  - REFRESH_DIV=1: index advances every cycle.
- Load:
  - load=1 at edge N: held <= bcd_in and invalid <= (any nibble of bcd_in > 9).
  - invalid is otherwise held; it clears only on a load of all-valid digits.
  - Load does not disturb the prescaler or index.
  - Load and an index advance at the same edge: both occur.
- Outputs are registered. At each non-reset edge they load from the pre-edge index and held value:
  - digit_idx <= index
  - an <= all ones except bit[index] = 0
  - {w3..w0} <= held[4*index+3 : 4*index]
- Latency:
  - Load at edge N is visible on w3..w0 at edge N+1 if that digit is selected.
  - An index change at edge N appears on an/digit_idx at edge N+1.
  - First valid digit drive is one cycle after rst deasserts.
- Leading-zero blanking (evaluated with blank_lz and held at the same edge as the output update):
  - Digit i > 0 is blank when blank_lz=1 and held digits i..DIGITS-1 are all 4'b0000.
  - Blank digit: w = 4'b1111 and an = all ones for that slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Non-BCD nibbles (10..15) are passed through unchanged; the convertor blanks them. The scanner does not substitute them.
- DIGITS=1: index and digit_idx are constantly 0 and an[0] is low every non-reset cycle.

Test Plan:
1. DIGITS=4, REFRESH_DIV=4, rst high 3 cycles, then low -> during reset an=4'b1111, w=4'b1111, invalid=0; one edge after release an=4'b1110, w=0, digit_idx=0.
2. Load bcd_in=16'h1234, blank_lz=0, run 16 cycles -> w sequence 4,3,2,1, each held 4 cycles; an sequence 1110,1101,1011,0111; then wraps to digit 0.
3. Load 16'h0042, blank_lz=1 -> digits 0,1 show 2,4 with their an low; slots 2,3 give an=4'b1111, w=4'b1111. Load 16'h0000 -> only digit 0 shows 0.
4. Load 16'h12A4 -> invalid=1 from next edge; slot 1 drives w=4'b1010. Load 16'h5678 -> invalid=0.
5. Assert load with 16'h9999 on the prescaler-wrap edge while index=3 -> next edge an=4'b1110, w=9.
6. Assert rst for one cycle mid-slot at index 2 -> outputs return to reset values at that edge; scanning restarts from digit 0; held value reads 0000.
